// File: rtl/shared_fu_arbiter_pkg.sv
// shared_fu_pkg: FSM state encoding and index-width helper for the shared functional-unit arbiter
package shared_fu_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/shared_fu_arbiter_if.sv
// shared_fu_arbiter_if: requester bundle plus the shared unit's operand/result lines
interface shared_fu_arbiter_if #(parameter int WIDTH = 32, parameter int NREQ = 4);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_left;
  logic [NREQ*WIDTH-1:0] req_right;
  logic [WIDTH-1:0]      out;
  logic [WIDTH-1:0]      fu_left;
  logic [WIDTH-1:0]      fu_right;
  logic [WIDTH-1:0]      fu_out;
  logic                  busy;
  modport master(output req_valid, req_left, req_right, fu_out, input req_ready, out, fu_left, fu_right, busy);
  modport slave(input req_valid, req_left, req_right, fu_out, output req_ready, out, fu_left, fu_right, busy);
endinterface

// File: rtl/shared_fu_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr, wrapping
module rr_arbiter import shared_fu_pkg::*; #(
  parameter int NREQ = 4,
  localparam int IW = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);
  logic found;
  always_comb begin
    found = 1'b0;
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        idx = IW'((int'(ptr) + k) % NREQ);
      end
    end
    gnt = found ? NREQ'(1) << idx : '0;
  end
endmodule

// File: rtl/shared_fu_arbiter.sv
// shared_fu_arbiter: time-shares one combinational functional unit among NREQ requesters
module shared_fu_arbiter import shared_fu_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int NREQ = 4,
  parameter int LATENCY = 2
) (
  input logic clk,
  input logic reset,
  shared_fu_arbiter_if.slave bus
);
  localparam int IW = idx_w(NREQ);
  localparam int CW = idx_w(LATENCY);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] ptr_q, ptr_d, grant_q, grant_d, arb_idx;
  logic [NREQ-1:0] arb_gnt;
  logic [WIDTH-1:0] left_q, left_d, right_q, right_d, out_q, out_d;
  rr_arbiter #(.NREQ(NREQ)) u_arb (.req(bus.req_valid), .ptr(ptr_q), .gnt(arb_gnt), .idx(arb_idx));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    grant_d = grant_q;
    left_d = left_q;
    right_d = right_q;
    out_d = out_q;
    case (state_q)
      IDLE: if (|arb_gnt) begin
        grant_d = arb_idx;
        left_d = bus.req_left[arb_idx*WIDTH +: WIDTH];
        right_d = bus.req_right[arb_idx*WIDTH +: WIDTH];
        cnt_d = CW'(LATENCY - 1);
        state_d = EXEC;
      end
      EXEC: if (cnt_q == '0) begin
        out_d = bus.fu_out;
        state_d = DONE;
      end else cnt_d = cnt_q - CW'(1);
      DONE: begin
        ptr_d = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + IW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ptr_q <= '0;
      grant_q <= '0;
      left_q <= '0;
      right_q <= '0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      grant_q <= grant_d;
      left_q <= left_d;
      right_q <= right_d;
      out_q <= out_d;
    end
  end
  assign bus.req_ready = (state_q == DONE) ? NREQ'(1) << grant_q : '0;
  assign bus.busy = state_q != IDLE;
  assign bus.out = out_q;
  assign bus.fu_left = left_q;
  assign bus.fu_right = right_q;
endmodule

// File: tb/tb_shared_fu_arbiter.sv
// tb_shared_fu_arbiter: directed checks of arbitration order, timing, abandonment and reset
module tb_shared_fu_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  int npulse;
  logic [3:0] p_rdy[8];
  int p_cyc[8];
  logic [31:0] p_out[8];
  shared_fu_arbiter_if #(.WIDTH(32), .NREQ(4)) bus_a ();
  shared_fu_arbiter_if #(.WIDTH(32), .NREQ(1)) bus_b ();
  shared_fu_arbiter #(.WIDTH(32), .NREQ(4), .LATENCY(2)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  shared_fu_arbiter #(.WIDTH(32), .NREQ(1), .LATENCY(1)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));
  assign bus_a.fu_out = bus_a.fu_left * bus_a.fu_right;
  assign bus_b.fu_out = bus_b.fu_left + bus_b.fu_right;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    bus_a.req_valid = '0;
    bus_b.req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic set_op(input int i, input logic [31:0] l, input logic [31:0] r);
    bus_a.req_left[i*32 +: 32] = l;
    bus_a.req_right[i*32 +: 32] = r;
  endtask
  task automatic run(input int n, input logic [3:0] drop);
    npulse = 0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (bus_a.req_ready != '0 && npulse < 8) begin
        p_rdy[npulse] = bus_a.req_ready;
        p_cyc[npulse] = c;
        p_out[npulse] = bus_a.out;
        npulse++;
        bus_a.req_valid = bus_a.req_valid & ~(bus_a.req_ready & drop);
      end
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [3:0] exp_rdy[4];
    bus_a.req_left = '0;
    bus_a.req_right = '0;
    bus_b.req_left = '0;
    bus_b.req_right = '0;
    do_reset();
    check("rst_busy", bus_a.busy, 0);
    check("rst_ready", bus_a.req_ready, 0);
    check("rst_out", bus_a.out, 0);
    check("rst_fu_left", bus_a.fu_left, 0);
    bus_a.req_valid = 4'b0010;
    set_op(1, 6, 7);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("single_busy_c%0d", c), bus_a.busy, (c <= 3) ? 1 : 0);
      check($sformatf("single_ready_c%0d", c), bus_a.req_ready, (c == 3) ? 4'b0010 : 4'b0000);
      if (c == 1) check("single_fu_left", bus_a.fu_left, 6);
      if (c == 3) begin
        check("single_out", bus_a.out, 42);
        bus_a.req_valid = '0;
      end
    end
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, i + 2, 10 + i);
    bus_a.req_valid = 4'b1111;
    run(16, 4'b1111);
    check("all4_npulse", npulse, 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("all4_rdy%0d", k), p_rdy[k], 4'b0001 << k);
      check($sformatf("all4_cyc%0d", k), p_cyc[k], 3 + 4 * k);
      check($sformatf("all4_out%0d", k), p_out[k], (k + 2) * (10 + k));
    end
    do_reset();
    set_op(2, 2, 2);
    bus_a.req_valid = 4'b0100;
    run(3, 4'b1111);
    @(negedge clk);
    set_op(1, 3, 5);
    set_op(3, 4, 9);
    bus_a.req_valid = 4'b1010;
    run(15, 4'b0000);
    bus_a.req_valid = '0;
    exp_rdy = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};
    check("rr_npulse", npulse, 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr_rdy%0d", k), p_rdy[k], exp_rdy[k]);
      check($sformatf("rr_cyc%0d", k), p_cyc[k], 3 + 4 * k);
      check($sformatf("rr_out%0d", k), p_out[k], (k % 2 == 0) ? 36 : 15);
    end
    do_reset();
    set_op(2, 5, 9);
    bus_a.req_valid = 4'b0100;
    @(negedge clk);
    check("abandon_busy", bus_a.busy, 1);
    set_op(2, 100, 100);
    bus_a.req_valid = '0;
    @(negedge clk);
    check("abandon_ready_c2", bus_a.req_ready, 0);
    check("abandon_fu_left", bus_a.fu_left, 5);
    @(negedge clk);
    check("abandon_ready_c3", bus_a.req_ready, 4'b0100);
    check("abandon_out", bus_a.out, 45);
    @(negedge clk);
    check("abandon_ready_c4", bus_a.req_ready, 0);
    check("abandon_idle", bus_a.busy, 0);
    do_reset();
    set_op(1, 3, 3);
    bus_a.req_valid = 4'b0010;
    run(3, 4'b1111);
    check("pre_rst_out", p_out[0], 9);
    @(negedge clk);
    set_op(0, 3, 4);
    bus_a.req_valid = 4'b0001;
    @(negedge clk);
    check("pre_rst_busy", bus_a.busy, 1);
    reset = 1'b1;
    bus_a.req_valid = '0;
    #1;
    check("midrst_ready", bus_a.req_ready, 0);
    check("midrst_busy", bus_a.busy, 0);
    check("midrst_out", bus_a.out, 0);
    check("midrst_fu_left", bus_a.fu_left, 0);
    @(negedge clk);
    reset = 1'b0;
    run(4, 4'b1111);
    check("midrst_no_pulse", npulse, 0);
    set_op(0, 2, 8);
    set_op(2, 7, 7);
    bus_a.req_valid = 4'b0101;
    run(3, 4'b1111);
    bus_a.req_valid = '0;
    check("postrst_npulse", npulse, 1);
    check("postrst_rdy", p_rdy[0], 4'b0001);
    check("postrst_cyc", p_cyc[0], 3);
    check("postrst_out", p_out[0], 16);
    do_reset();
    bus_b.req_left = 32'hFFFF_FFFF;
    bus_b.req_right = 32'd1;
    bus_b.req_valid = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check($sformatf("n1_ready_c%0d", c), bus_b.req_ready, (c == 2 || c == 5) ? 1 : 0);
      check($sformatf("n1_busy_c%0d", c), bus_b.busy, (c == 3 || c == 6) ? 0 : 1);
      if (c == 2) begin
        check("n1_wrap_out", bus_b.out, 0);
        bus_b.req_left = 32'd5;
        bus_b.req_right = 32'd6;
      end
      if (c == 5) begin
        check("n1_add_out", bus_b.out, 11);
        bus_b.req_valid = 1'b0;
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/shared_fu_arbiter.md
# shared_fu_arbiter

Round-robin arbiter and sequencer that shares one external combinational functional unit (std_mul, std_div, std_add, …) among NREQ requesters. It latches the granted requester's operands, holds them stable on the unit for LATENCY cycles, registers the result, and returns it with a one-cycle ready pulse. It sits between Calyx-generated group logic and a single expensive arithmetic primitive, so that one multiplier or divider can serve several groups.

## Interface
- WIDTH, 32, operand and result width
- NREQ, 4, number of requesters, ≥1
- LATENCY, 2, cycles operands are held on the unit before fu_out is captured, ≥1
- clk  in  1  clock, all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req_valid  in  NREQ  bit i: requester i has an operation pending
- req_left  in  NREQ*WIDTH  requester i left operand at [i*WIDTH +: WIDTH]
- req_right  in  NREQ*WIDTH  requester i right operand, same packing
- req_ready  out  NREQ  one-hot; bit i pulses one cycle when requester i's result is on out
- out  out  WIDTH  last captured result, held until the next capture
- fu_left  out  WIDTH  left operand to the shared unit
- fu_right  out  WIDTH  right operand to the shared unit
- fu_out  in  WIDTH  shared unit result, combinational in fu_left/fu_right
- busy  out  1  high when state ≠ IDLE

## Operation
- FSM states: IDLE, EXEC, DONE. Reset state is IDLE.
- IDLE: if any req_valid bit is set, grant the first set bit at or after rr_ptr, searching upward and wrapping modulo NREQ. Latch the grant index, req_left, and req_right. Load cnt = LATENCY-1. Go to EXEC. If no bit is set, stay in IDLE.
- EXEC: fu_left/fu_right come from the operand latches, so they are stable for the whole state. When cnt==0, capture fu_out into out and go to DONE. Otherwise decrement cnt.
- DONE: req_ready[grant]=1 for exactly this cycle. rr_ptr ← (grant+1) mod NREQ. Go to IDLE.
- fu_left/fu_right always show the operand latches, including in IDLE.
- Result width is exactly WIDTH bits. fu_out is captured unmodified; there is no extension or truncation. Grant index width is max(1, $clog2(NREQ)).
- Handshake: a requester holds req_valid and its operands until it sees its req_ready bit. It must drop req_valid at or before the edge that ends the ready cycle. A req_valid still high in the following IDLE cycle is a new request.
- Operands are sampled once, at the grant edge. Later operand changes, or req_valid falling during EXEC or DONE, do not affect the operation: it completes and ready still pulses.
- Requests arriving during EXEC or DONE wait. They are only considered in IDLE.
- With NREQ=1, rr_ptr stays 0 and arbitration is trivial.
- Reset, asynchronous at any time, including mid-EXEC or mid-DONE:
  - state=IDLE; rr_ptr, cnt, grant, operand latches, and out are all 0.
  - req_ready=0 and busy=0 immediately.
  - The aborted operation produces no ready pulse.

## Timing
- Cycle 0 is the first cycle req_valid is high while in IDLE. The grant and latch happen at the end of cycle 0.
- EXEC occupies cycles 1..LATENCY. fu_out is captured at the end of cycle LATENCY.
- req_ready is high in cycle LATENCY+1, and out is valid from that cycle.
- The earliest next grant is at the end of cycle LATENCY+2, so back-to-back throughput is one operation per LATENCY+2 cycles.
- No combinational path from any input to any output. req_ready, out, fu_left, fu_right, and busy are all decoded from registers.

## Structure
- Package shared_fu_pkg:
  - state_t enum (IDLE, EXEC, DONE)
  - localparam-style helper function for the grant-index width
- Sub-module rr_arbiter, combinational:
  - inputs: req (NREQ) and ptr
  - outputs: one-hot grant and grant index
  - reused by other shared-resource controllers
- Top level holds the FSM, cnt, rr_ptr, operand latches, and result register.

## Test plan
- Single request, NREQ=4, LATENCY=2, fu = std_mul model: req_valid=4'b0010 with left=6, right=7 at cycle 0 → req_ready=4'b0010 in cycle 3 only, out=42, busy high in cycles 1–3.
- Simultaneous requests after reset: all four valid, each dropping valid after its ready → grants in order 0,1,2,3, ready pulses in cycles 3, 7, 11, 15.
- Fairness and wrap: requesters 1 and 3 held continuously, with rr_ptr reaching 3 first → grant sequence 3,1,3,1. Requester 3 is never granted twice in a row.
- Mid-operation abandonment: req_valid[2] and its operands changed during EXEC → ready[2] still pulses in cycle LATENCY+1, and out is the product of the originally sampled operands.
- Reset during EXEC: reset asserted in cycle 1 → req_ready=0 and busy=0 immediately, out=0, no ready pulse; the next request is granted from rr_ptr=0.
- Boundary configuration NREQ=1, LATENCY=1, fu = std_add model: 0xFFFFFFFF + 1 → out=0 (wrap) and ready in cycle 2; back-to-back operations are 3 cycles apart.
